// File: rtl/sd_dat_block_receiver.sv
// sd_dat_block_receiver
//
// Receives one or more data blocks from a 1- or 4-lane SD DAT bus. It assembles
// bytes, checks the end bits and, optionally, the CRC16 of each lane, and detects
// start-bit timeouts. It hands the received bytes to the host side through a
// valid/ready interface. All DAT sampling happens only on ex_clk edges where
// sd_clk_en_i is high ("ticks").
//
// Optional feature (build macro SD_DAT_CRC_CHECK_EN):
//   defined   - per-lane CRC16 generators (x^16+x^12+x^5+1, init 0) are built, and
//               the 16 CRC ticks are compared against them.
//   undefined - no CRC logic is built. The CRC ticks are consumed and discarded,
//               crc_err_lane_o is tied to 0, and crc_err_o reports end-bit errors only.
//
// Ports:
//   ex_clk_i        system clock
//   ex_resetn_i     asynchronous active-low reset
//   sd_clk_en_i     one-cycle strobe at each SD sampling point
//   start_i         begin a transfer (sampled only while idle)
//   wide_bus_i      1 = 4-lane mode (forced to 1-lane when DAT_WIDTH=1), latched on start
//   block_count_i   blocks to receive, latched on start; 0 behaves as 1
//   sd_dat_in_i     DAT pins
//   byte_out_o      received byte
//   byte_valid_o    byte_out_o holds an unconsumed byte
//   byte_ready_i    consumer accepts byte_out_o when valid and ready are both high
//   busy_o          transfer in progress
//   block_done_o    one-cycle pulse after each block's end bit
//   done_o          one-cycle pulse when the transfer terminates
//   crc_err_o       sticky CRC or end-bit error
//   crc_err_lane_o  sticky per-lane CRC error
//   timeout_err_o   sticky start-bit timeout
//   overrun_err_o   sticky; a byte completed while the previous one was unconsumed
module sd_dat_block_receiver #(
    parameter int unsigned DAT_WIDTH     = 4,
    parameter int unsigned BLOCK_BYTES   = 512,
    parameter int unsigned TIMEOUT_TICKS = 65535
) (
    input  logic                 ex_clk_i,
    input  logic                 ex_resetn_i,
    input  logic                 sd_clk_en_i,
    input  logic                 start_i,
    input  logic                 wide_bus_i,
    input  logic [15:0]          block_count_i,
    input  logic [DAT_WIDTH-1:0] sd_dat_in_i,
    output logic [7:0]           byte_out_o,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i,
    output logic                 busy_o,
    output logic                 block_done_o,
    output logic                 done_o,
    output logic                 crc_err_o,
    output logic [DAT_WIDTH-1:0] crc_err_lane_o,
    output logic                 timeout_err_o,
    output logic                 overrun_err_o
);

    localparam int unsigned TmoW  = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned ByteW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StData,
        StCrc,
        StEnd,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic              wide_q, wide_d;
    logic [15:0]       blk_q, blk_d;
    logic [TmoW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic [2:0]        bit_q, bit_d;
    logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [3:0]        crc_cnt_q, crc_cnt_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic              byte_valid_q, byte_valid_d;
    logic              block_done_q, block_done_d;
    logic              crc_err_q, crc_err_d;
    logic              tmo_err_q, tmo_err_d;
    logic              ovr_err_q, ovr_err_d;
    logic              new_byte, last_bit, hs;
    logic [3:0]        dat4, active;

    // Normalise the pins to four lanes; unused lanes read 0 and are masked anyway.
    if (DAT_WIDTH == 4) begin : g_dat_wide
        assign dat4 = sd_dat_in_i;
    end else begin : g_dat_narrow
        assign dat4 = {3'b000, sd_dat_in_i[0]};
    end

    assign active  = wide_q ? 4'hF : 4'h1;
    assign tmo_inc = tmo_q + 1'b1;
    assign hs      = byte_valid_q & byte_ready_i;

`ifdef SD_DAT_CRC_CHECK_EN
    logic                 crc_clear, crc_feed, crc_shift;
    logic [3:0]           crc_msb, mismatch;
    logic [DAT_WIDTH-1:0] lane_err_q, lane_err_d;

    for (genvar n = 0; n < 4; n++) begin : g_crc
        logic [15:0] crc_q, crc_d;

        always_comb begin
            crc_d = crc_q;
            if (crc_clear) begin
                crc_d = '0;
            end else if (crc_feed && active[n]) begin
                crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ dat4[n]) ? 16'h1021 : 16'h0000);
            end else if (crc_shift) begin
                // Shift the expected CRC out MSB first while comparing.
                crc_d = {crc_q[14:0], 1'b0};
            end
        end

        always_ff @(posedge ex_clk_i or negedge ex_resetn_i) begin
            if (!ex_resetn_i) begin
                crc_q <= '0;
            end else begin
                crc_q <= crc_d;
            end
        end

        assign crc_msb[n] = crc_q[15];
    end

    assign mismatch       = (dat4 ^ crc_msb) & active;
    assign crc_err_lane_o = lane_err_q;
`else
    assign crc_err_lane_o = '0;
`endif

    always_comb begin
        state_d      = state_q;
        wide_d       = wide_q;
        blk_d        = blk_q;
        tmo_d        = tmo_q;
        bit_d        = bit_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        crc_cnt_d    = crc_cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        block_done_d = 1'b0;
        crc_err_d    = crc_err_q;
        tmo_err_d    = tmo_err_q;
        ovr_err_d    = ovr_err_q;
        new_byte     = 1'b0;
        last_bit     = 1'b0;
`ifdef SD_DAT_CRC_CHECK_EN
        crc_clear    = 1'b0;
        crc_feed     = 1'b0;
        crc_shift    = 1'b0;
        lane_err_d   = lane_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StWaitStart;
                    wide_d     = wide_bus_i && (DAT_WIDTH == 4);
                    blk_d      = (block_count_i == 16'd0) ? 16'd1 : block_count_i;
                    tmo_d      = '0;
                    bit_d      = '0;
                    byte_cnt_d = '0;
                    crc_cnt_d  = '0;
                    crc_err_d  = 1'b0;
                    tmo_err_d  = 1'b0;
                    ovr_err_d  = 1'b0;
`ifdef SD_DAT_CRC_CHECK_EN
                    crc_clear  = 1'b1;
                    lane_err_d = '0;
`endif
                end
            end

            StWaitStart: begin
                if (sd_clk_en_i) begin
                    if ((dat4 & active) == 4'h0) begin
                        state_d = StData;
                        tmo_d   = '0;
                    end else if (tmo_inc == TmoW'(TIMEOUT_TICKS)) begin
                        tmo_d     = tmo_inc;
                        tmo_err_d = 1'b1;
                        state_d   = StFinish;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end

            StData: begin
                if (sd_clk_en_i) begin
`ifdef SD_DAT_CRC_CHECK_EN
                    crc_feed = 1'b1;
`endif
                    if (wide_q) begin
                        shift_d  = {shift_q[3:0], dat4};
                        last_bit = bit_q[0];
                    end else begin
                        shift_d  = {shift_q[6:0], dat4[0]};
                        last_bit = (bit_q == 3'd7);
                    end
                    if (last_bit) begin
                        bit_d    = '0;
                        new_byte = 1'b1;
                        if (byte_cnt_q == ByteW'(BLOCK_BYTES - 1)) begin
                            byte_cnt_d = '0;
                            crc_cnt_d  = '0;
                            state_d    = StCrc;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            StCrc: begin
                if (sd_clk_en_i) begin
`ifdef SD_DAT_CRC_CHECK_EN
                    crc_shift  = 1'b1;
                    lane_err_d = lane_err_q | mismatch[DAT_WIDTH-1:0];
                    if (mismatch != 4'h0) begin
                        crc_err_d = 1'b1;
                    end
`endif
                    crc_cnt_d = crc_cnt_q + 4'd1;
                    if (crc_cnt_q == 4'd15) begin
                        state_d = StEnd;
                    end
                end
            end

            StEnd: begin
                if (sd_clk_en_i) begin
                    block_done_d = 1'b1;
                    if ((~dat4 & active) != 4'h0) begin
                        crc_err_d = 1'b1;
                    end
                    // The error decision includes an end-bit error seen on this very tick.
                    if (crc_err_d || (blk_q == 16'd1)) begin
                        state_d = StFinish;
                    end else begin
                        blk_d   = blk_q - 16'd1;
                        tmo_d   = '0;
                        state_d = StWaitStart;
`ifdef SD_DAT_CRC_CHECK_EN
                        crc_clear = 1'b1;
`endif
                    end
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A handshake in the same cycle as a new byte frees the slot, so no overrun.
        if (new_byte) begin
            byte_out_d   = shift_d;
            byte_valid_d = 1'b1;
            if (byte_valid_q && !hs) begin
                ovr_err_d = 1'b1;
            end
        end else if (hs) begin
            byte_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ex_clk_i or negedge ex_resetn_i) begin
        if (!ex_resetn_i) begin
            state_q      <= StIdle;
            wide_q       <= 1'b0;
            blk_q        <= '0;
            tmo_q        <= '0;
            bit_q        <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            crc_cnt_q    <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            block_done_q <= 1'b0;
            crc_err_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
            ovr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wide_q       <= wide_d;
            blk_q        <= blk_d;
            tmo_q        <= tmo_d;
            bit_q        <= bit_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            crc_cnt_q    <= crc_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            block_done_q <= block_done_d;
            crc_err_q    <= crc_err_d;
            tmo_err_q    <= tmo_err_d;
            ovr_err_q    <= ovr_err_d;
        end
    end

`ifdef SD_DAT_CRC_CHECK_EN
    always_ff @(posedge ex_clk_i or negedge ex_resetn_i) begin
        if (!ex_resetn_i) begin
            lane_err_q <= '0;
        end else begin
            lane_err_q <= lane_err_d;
        end
    end
`endif

    assign byte_out_o    = byte_out_q;
    assign byte_valid_o  = byte_valid_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StFinish);
    assign block_done_o  = block_done_q;
    assign crc_err_o     = crc_err_q;
    assign timeout_err_o = tmo_err_q;
    assign overrun_err_o = ovr_err_q;

endmodule

// File: doc/sd_dat_block_receiver.md
Name: sd_dat_block_receiver

Overview:
- Parametrised SD DAT-line block receiver; next-generation companion to the existing command-path receive logic.
- Captures one or more data blocks from a 1- or 4-lane DAT bus, assembles bytes and checks per-lane CRC16 and end bits.
- Provides timeout detection and a byte stream with valid/ready handoff to the host-side logic.
- Runs on ex_clk; SD clock timing comes from a one-cycle sample strobe, sd_clk_en, generated by the SD clock divider.

Parameters:
- DAT_WIDTH, 4, physical DAT lanes; legal values 1 or 4.
- BLOCK_BYTES, 512, bytes per block; legal range 1..4096.
- TIMEOUT_TICKS, 65535, sd_clk_en ticks allowed while waiting for a start bit.

Ports:
- ex_clk, input, 1: system clock.
- ex_resetn, input, 1: reset, asynchronous, active-low.
- sd_clk_en, input, 1: single-ex_clk pulse at each SD sampling point.
- start, input, 1: begin a transfer; sampled only in IDLE.
- wide_bus, input, 1: 1 selects 4-lane mode; ignored (1-lane) when DAT_WIDTH=1; latched on start.
- block_count, input, 16: blocks to receive; latched on start; 0 is treated as 1.
- sd_dat_in, input, DAT_WIDTH: DAT pins.
- byte_out, output, 8: received byte.
- byte_valid, output, 1: byte_out holds an unconsumed byte.
- byte_ready, input, 1: consumer accepts byte_out when byte_valid and byte_ready are both 1.
- busy, output, 1: transfer in progress.
- block_done, output, 1: one-cycle pulse after each block's end bit.
- done, output, 1: one-cycle pulse when the transfer terminates.
- crc_err, output, 1: sticky CRC or end-bit error.
- crc_err_lane, output, DAT_WIDTH: sticky per-lane CRC error.
- timeout_err, output, 1: sticky start-bit timeout.
- overrun_err, output, 1: sticky; a byte arrived while byte_valid=1.

Behaviour:
- Reset: all outputs 0, state IDLE, counters and CRC registers 0.
- Error flags and crc_err_lane clear on an accepted start and otherwise hold.
- Active lanes: 4-lane mode uses lanes 3..0; 1-lane mode uses lane 0 only.
- All data, CRC and end-bit samples are taken only on ex_clk edges where sd_clk_en=1 ("ticks").

State machine:
- IDLE -> WAIT_START on start=1. Sets busy=1, loads the block counter and clears the timeout counter. start while busy is ignored.
- WAIT_START:
  - Each tick increments the timeout counter.
  - If all active lanes read 0 -> DATA; clear the timeout counter.
  - Else if the counter reaches TIMEOUT_TICKS -> set timeout_err, go to FINISH.
- DATA:
  - 1-lane mode: 8 ticks per byte, MSB first.
  - 4-lane mode: 2 ticks per byte, high nibble first; lane 3 is the MSB of each nibble.
  - Each active lane's bit feeds that lane's CRC16 (polynomial x^16+x^12+x^5+1, init 0).
  - After BLOCK_BYTES bytes -> CRC.
- CRC:
  - 16 ticks; each lane's received bits are compared MSB first against its computed CRC.
  - A mismatch on lane n sets crc_err_lane[n] and crc_err.
  - After the 16th tick -> END.
- END:
  - 1 tick; any active lane reading 0 sets crc_err.
  - Pulse block_done.
  - If crc_err=1 or this was the last block -> FINISH; else decrement the block counter, clear CRCs -> WAIT_START.
- FINISH: pulse done for 1 cycle, clear busy -> IDLE.

Byte handoff:
- A completed byte is written to byte_out with byte_valid=1 on the same ex_clk edge as its final data tick.
- byte_valid clears on handshake.
- If a new byte completes while byte_valid=1 and no handshake occurs that cycle: set overrun_err, overwrite byte_out, keep byte_valid=1.
- A handshake and a new byte in the same cycle is not an overrun: the new byte is loaded and byte_valid stays 1.
- byte_valid is not cleared by done; an unconsumed final byte remains available.

Other rules:
- sd_clk_en held 0: the FSM freezes, and the timeout counter does not advance.
- Reset asserted mid-transfer: immediate return to the reset state; no done pulse.

Optional Feature:
- Macro: SD_DAT_CRC_CHECK_EN.
- Defined: CRC16 generators and comparison as described above.
- Undefined:
  - No CRC logic is built; the 16 CRC ticks are still consumed and discarded.
  - crc_err_lane is tied to 0; crc_err is set only by end-bit errors.

Test Plan:
- 4-lane, BLOCK_BYTES=4, block_count=1, bytes A5 3C FF 00 with correct CRCs and end bit -> byte_out sequence A5,3C,FF,00; one block_done, then done; crc_err=0.
- 1-lane, wide_bus=0, same bytes -> identical byte stream after 32 data ticks; lanes 3..1 driven X without effect.
- 4-lane with lane 2's CRC bit 7 flipped -> crc_err=1, crc_err_lane=4'b0100, done after that block even with block_count=3.
- DAT held 1, TIMEOUT_TICKS=100 -> timeout_err=1 and done at tick 100; no block_done; busy=0.
- byte_ready=0 throughout a 4-byte block -> overrun_err=1, byte_out=00 at done.
- block_count=0 -> exactly one block received; ex_resetn pulsed low mid-DATA -> all outputs 0, no done pulse.
